ex_div_stage: RTL and testbench

EX_DIV_STAGE -- requirements
Module: ex_div_stage

---
 rtl/ex_div_stage.sv | 118 +++++++++++
 tb/tb_ex_div_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_div_stage.sv
// ex_div_stage: RV32 execute stage with single-cycle ALU/MUL and a multi-cycle restoring divider
module ex_div_stage #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] inst_i,
   input  logic [31:0] instaddr_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic        regs_wen_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        flush_i,
   output logic [31:0] rd_data_o,
   output logic        regs_wen_o,
   output logic [4:0]  rd_addr_o,
   output logic        hold_o
);
   localparam int CW = $clog2(DIV_CYCLES + 1);
   localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;
   logic [1:0]         r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [31:0]        r_dividend, r_divisor, r_quot, r_rem;
   logic               r_neg_q, r_neg_r, r_is_rem;
   logic [6:0]         w_op, w_f7;
   logic [2:0]         w_f3;
   logic [4:0]         w_sh;
   logic               w_is_r, w_is_i, w_alt, w_alu_ok, w_md, w_mul, w_div;
   logic               w_dsigned, w_dzero, w_ovf, w_start, w_qbit, w_wen, w_unused;
   logic [31:0]        w_alu, w_sra, w_mul_res, w_fast, w_div_res, w_abs1, w_abs2, w_rd_data;
   logic signed [32:0] w_ma, w_mb;
   logic signed [65:0] w_prod;
   logic [32:0]        w_rem_sh, w_diff;
   assign w_op     = inst_i[6:0];
   assign w_f3     = inst_i[14:12];
   assign w_f7     = inst_i[31:25];
   assign w_sh     = op2_i[4:0];
   assign w_is_r   = w_op == 7'b0110011;
   assign w_is_i   = w_op == 7'b0010011;
   assign w_alt    = w_f7 == 7'b0100000;
   assign w_alu_ok = (w_is_r && (w_f7 == 7'd0 || (w_alt && (w_f3 == 3'd0 || w_f3 == 3'd5))))
                  || (w_is_i && (w_f3 == 3'd1 ? w_f7 == 7'd0 : (w_f3 != 3'd5 || w_f7 == 7'd0 || w_alt)));
   assign w_md     = w_is_r && w_f7 == 7'b0000001;
   assign w_mul    = w_md && !w_f3[2];
   assign w_div    = w_md && w_f3[2];
   assign w_sra    = $signed(op1_i) >>> w_sh;
   assign w_unused = ^{instaddr_i, inst_i[24:7], w_prod[65:64]};
   always_comb begin
      case (w_f3)
         3'd0:    w_alu = (w_is_r && w_alt) ? op1_i - op2_i : op1_i + op2_i;
         3'd1:    w_alu = op1_i << w_sh;
         3'd2:    w_alu = {31'd0, $signed(op1_i) < $signed(op2_i)};
         3'd3:    w_alu = {31'd0, op1_i < op2_i};
         3'd4:    w_alu = op1_i ^ op2_i;
         3'd5:    w_alu = w_alt ? w_sra : op1_i >> w_sh;
         3'd6:    w_alu = op1_i | op2_i;
         default: w_alu = op1_i & op2_i;
      endcase
   end
   // one extra sign bit per operand covers MUL/MULH/MULHSU/MULHU with a single signed multiplier
   assign w_ma      = {w_f3[1:0] != 2'b11 && op1_i[31], op1_i};
   assign w_mb      = {w_f3[1:0] == 2'b01 && op2_i[31], op2_i};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = w_f3[1:0] == 2'b00 ? w_prod[31:0] : w_prod[63:32];
   assign w_dsigned = !w_f3[0];
   assign w_dzero   = op2_i == 32'd0;
   assign w_ovf     = w_dsigned && op1_i == 32'h8000_0000 && op2_i == 32'hFFFF_FFFF;
   assign w_fast    = w_dzero ? (w_f3[1] ? op1_i : '1) : (w_f3[1] ? '0 : 32'h8000_0000);
   assign w_start   = r_state == S_IDLE && w_div && !w_dzero && !w_ovf && !flush_i;
   assign w_abs1    = (w_dsigned && op1_i[31]) ? -op1_i : op1_i;
   assign w_abs2    = (w_dsigned && op2_i[31]) ? -op2_i : op2_i;
   assign w_rem_sh  = {r_rem, r_dividend[31]};
   assign w_diff    = w_rem_sh - {1'b0, r_divisor};
   assign w_qbit    = !w_diff[32];
   assign w_div_res = r_is_rem ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quot : r_quot);
   assign w_next    = flush_i ? S_IDLE : w_start ? S_CALC
                    : r_state == S_CALC ? (r_cnt == CW'(DIV_CYCLES - 1) ? S_DONE : S_CALC) : S_IDLE;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_is_rem   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (flush_i) begin
            r_cnt <= '0;
         end else if (w_start) begin
            r_cnt      <= '0;
            r_dividend <= w_abs1;
            r_divisor  <= w_abs2;
            r_quot     <= '0;
            r_rem      <= '0;
            r_neg_q    <= w_dsigned && (op1_i[31] ^ op2_i[31]);
            r_neg_r    <= w_dsigned && op1_i[31];
            r_is_rem   <= w_f3[1];
         end else if (r_state == S_CALC) begin
            r_cnt      <= r_cnt + 1'b1;
            r_dividend <= {r_dividend[30:0], 1'b0};
            r_quot     <= {r_quot[30:0], w_qbit};
            r_rem      <= w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
         end
      end
   end
   assign w_rd_data  = r_state == S_DONE ? w_div_res : r_state == S_CALC ? '0
                     : w_alu_ok ? w_alu : w_mul ? w_mul_res : (w_div && !w_start) ? w_fast : '0;
   assign w_wen      = regs_wen_i && (r_state == S_DONE
                     || (r_state != S_CALC && (w_alu_ok || w_mul || (w_div && !w_start))));
   assign rd_data_o  = rstn ? w_rd_data : '0;
   assign regs_wen_o = rstn && !flush_i && w_wen;
   assign hold_o     = rstn && (w_start || (r_state == S_CALC && !flush_i));
   assign rd_addr_o  = rstn ? rd_addr_i : '0;
endmodule

// File: tb/tb_ex_div_stage.sv
// tb_ex_div_stage: directed and randomized checks of ex_div_stage against an arithmetic reference model
module tb_ex_div_stage;
   logic        clk = 1'b0, rstn = 1'b0;
   logic [31:0] inst_i = '0, instaddr_i = '0, op1_i = '0, op2_i = '0;
   logic        regs_wen_i = 1'b0, flush_i = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic [31:0] rd_data_o;
   logic        regs_wen_o, hold_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] cur_inst = '0;
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   ex_div_stage dut (
      .clk(clk), .rstn(rstn), .inst_i(inst_i), .instaddr_i(instaddr_i), .op1_i(op1_i),
      .op2_i(op2_i), .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
      .rd_data_o(rd_data_o), .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .hold_o(hold_o)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst=%h got=%h exp=%h", tag, cur_inst, got, exp);
      end
   endtask
   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
      return {f7, 5'd2, 5'd1, f3, 5'd3, op};
   endfunction
   function automatic logic [32:0] ref_res(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [63:0] p;
      logic [31:0] r;
      logic ok;
      longint sa, sb;
      longint unsigned ua, ub;
      op = inst[6:0];
      f3 = inst[14:12];
      f7 = inst[31:25];
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      r = '0;
      ok = 1'b0;
      if (op == 7'h33 && f7 == 7'h01) begin
         ok = 1'b1;
         if (f3 == 3'd0) begin p = ua * ub; r = p[31:0]; end
         else if (f3 == 3'd1) begin p = sa * sb; r = p[63:32]; end
         else if (f3 == 3'd2) begin p = sa * longint'(ub); r = p[63:32]; end
         else if (f3 == 3'd3) begin p = ua * ub; r = p[63:32]; end
         else if (b == 0) r = f3[1] ? a : 32'hFFFF_FFFF;
         else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f3[1] ? 32'd0 : a;
         else if (f3[0]) r = f3[1] ? a % b : a / b;
         else if (f3[1]) r = $signed(a) % $signed(b);
         else r = $signed(a) / $signed(b);
      end else if (op == 7'h33 || op == 7'h13) begin
         ok = op == 7'h13 ? (f3 != 3'd1 || f7 == 7'd0) && (f3 != 3'd5 || f7 == 7'd0 || f7 == 7'h20)
                          : (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         case (f3)
            3'd0: r = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (f7 == 7'h20) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
         endcase
         if (!ok) r = '0;
      end
      return {ok, r};
   endfunction
   function automatic int ref_hold(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
      if (inst[6:0] == 7'h33 && inst[31:25] == 7'h01 && inst[14] && b != 0
          && !(!inst[12] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 33;
      return 0;
   endfunction
   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction
   task automatic put(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(posedge clk);
      #1;
      inst_i = inst;
      op1_i = a;
      op2_i = b;
      rd_addr_i = rd;
      regs_wen_i = 1'b1;
      flush_i = 1'b0;
      instaddr_i = instaddr_i + 32'd4;
      cur_inst = inst;
   endtask
   task automatic issue_check(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] exp;
      logic [4:0] rd;
      logic bad;
      int n;
      exp = ref_res(inst, a, b);
      rd = 5'($urandom);
      bad = 1'b0;
      n = 0;
      put(inst, a, b, rd);
      @(negedge clk);
      while (hold_o && n < 40) begin
         bad = bad | regs_wen_o;
         n++;
         @(negedge clk);
      end
      chk("hold_cycles", n, ref_hold(inst, a, b));
      chk("wen_in_hold", {31'd0, bad}, 32'd0);
      chk("rd_data", rd_data_o, exp[31:0]);
      chk("regs_wen", {31'd0, regs_wen_o}, {31'd0, exp[32]});
      chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, rd});
   endtask
   initial begin
      inst_i = enc(7'h00, 3'd0, 7'h33);
      op1_i = 32'd5;
      op2_i = 32'hFFFF_FFFD;
      regs_wen_i = 1'b1;
      rd_addr_i = 5'd9;
      @(negedge clk);
      chk("rst_data", rd_data_o, 32'd0);
      chk("rst_wen", {31'd0, regs_wen_o}, 32'd0);
      chk("rst_hold", {31'd0, hold_o}, 32'd0);
      chk("rst_addr", {27'd0, rd_addr_o}, 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;
      issue_check(enc(7'h00, 3'd0, 7'h33), 32'd5, 32'hFFFF_FFFD);
      chk("add_const", rd_data_o, 32'd2);
      issue_check(enc(7'h01, 3'd4, 7'h33), 32'hFFFF_FF9C, 32'd7);
      chk("div_const", rd_data_o, 32'hFFFF_FFF2);
      issue_check(enc(7'h01, 3'd6, 7'h33), 32'hFFFF_FF9C, 32'd7);
      chk("rem_const", rd_data_o, 32'hFFFF_FFFE);
      issue_check(enc(7'h01, 3'd5, 7'h33), 32'd10, 32'd0);
      chk("divu0_const", rd_data_o, 32'hFFFF_FFFF);
      issue_check(enc(7'h01, 3'd6, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF);
      chk("rem_ovf_const", rd_data_o, 32'd0);
      issue_check(enc(7'h00, 3'd0, 7'h7F), 32'd3, 32'd4);
      issue_check(enc(7'h20, 3'd1, 7'h33), 32'd3, 32'd4);
      put(enc(7'h01, 3'd4, 7'h33), 32'hFFFF_FF9C, 32'd7, 5'd4);
      repeat (10) @(posedge clk);
      #1 flush_i = 1'b1;
      @(negedge clk);
      chk("flush_hold", {31'd0, hold_o}, 32'd0);
      chk("flush_wen", {31'd0, regs_wen_o}, 32'd0);
      issue_check(enc(7'h00, 3'd0, 7'h33), 32'd5, 32'hFFFF_FFFD);
      chk("add_after_flush", rd_data_o, 32'd2);
      put(enc(7'h01, 3'd5, 7'h33), 32'd100, 32'd7, 5'd6);
      repeat (20) @(posedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      chk("midrst_data", rd_data_o, 32'd0);
      chk("midrst_wen", {31'd0, regs_wen_o}, 32'd0);
      chk("midrst_hold", {31'd0, hold_o}, 32'd0);
      chk("midrst_addr", {27'd0, rd_addr_o}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      inst_i = '0;
      issue_check(enc(7'h01, 3'd5, 7'h33), 32'd100, 32'd7);
      chk("divu_after_rst", rd_data_o, 32'd14);
      for (int i = 0; i < 150; i++) begin
         logic [2:0] f3;
         logic [6:0] f7;
         logic [31:0] inst, a, b;
         f3 = 3'($urandom);
         a = pick();
         b = pick();
         case ($urandom_range(0, 3))
            0: inst = enc(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, f3, 7'h33);
            1: begin
               f7 = f3 == 3'd1 ? 7'h00 : f3 == 3'd5 ? ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00) : 7'($urandom);
               inst = enc(f7, f3, 7'h13);
            end
            2: inst = enc(7'h01, {1'b0, f3[1:0]}, 7'h33);
            default: begin
               inst = enc(7'h01, {1'b1, f3[1:0]}, 7'h33);
               if ($urandom_range(0, 5) == 0) b = '0;
            end
         endcase
         issue_check(inst, a, b);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
